pwm_carrier_gen: RTL
====================

# pwm_carrier_gen

Carrier generator for the PWM path. It produces the 16-bit ramp `count` and the double-buffered duty threshold `ref_out` that feed the 16-bit magnitude comparator stage (`count > ref_out` → PWM high). Period and duty updates from the control side are captured immediately but take effect only at a carrier boundary, so the comparator never sees a torn period.

## Interface
- `WIDTH`, 16, width of the counter, period and duty values.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; low freezes the carrier.
- `mode`  in  1  0 = sawtooth (up), 1 = triangle (up/down); sampled only at a boundary.
- `period_in`  in  WIDTH  carrier peak value P.
- `duty_in`  in  WIDTH  comparator threshold.
- `load`  in  1  one-cycle strobe that captures `period_in`, `duty_in` and `mode` into the pending registers.
- `count`  out  WIDTH  carrier value, drives the comparator `in`.
- `ref_out`  out  WIDTH  active duty threshold, drives the comparator `ref`.
- `period_end`  out  1  one-cycle pulse in the first cycle after the carrier returns to 0.
- `peak`  out  1  one-cycle pulse while `count` equals P in triangle mode.
- `load_ack`  out  1  one-cycle pulse when the pending values become active.

## Operation
- Registers:
  - pending set {`p_pend`, `d_pend`, `m_pend`} plus `pend_flag`.
  - active set {`p_act`, `d_act` (= `ref_out`), `m_act`}.
- States:
  - IDLE → UP when `en`=1.
  - UP → UP (`count`+1) while `count` < `p_act`.
  - At `count` == `p_act` in UP:
    - sawtooth → boundary, next `count` = 0, stay UP.
    - triangle → DOWN, next `count` = `p_act`−1.
  - DOWN → DOWN (`count`−1) while `count` > 1.
  - At `count` == 1 in DOWN → boundary, next `count` = 0, state UP.
- Boundary actions, all in the same edge as the wrap to 0:
  - If `pend_flag`=1: pending set → active set, clear `pend_flag`, assert `load_ack` next cycle.
  - Assert `period_end` next cycle.
- IDLE exit is treated as a boundary: pending values apply, `count` = 0.
- `load`:
  - Writes the pending set and sets `pend_flag`.
  - A second `load` before the boundary overwrites the pending set; only one `load_ack` follows.
  - A `load` in the same cycle as a boundary goes to pending and applies at the following boundary; the boundary uses the old pending contents.
- `p_act` = 0: `count` holds 0; every enabled cycle is a boundary; `period_end` stays high. Triangle mode with P=0 behaves the same.
- `p_act` = 1 in triangle mode: sequence 0,1,0,1…; `peak` fires on each 1.
- Arithmetic is unsigned, `WIDTH` bits. P = 16'hFFFF is legal: sawtooth wraps 16'hFFFF → 0 with no overflow flag.
- `en`=0: `count`, state and active set hold. `load` is still accepted. No pulses are generated.
- Reset values:
  - `count`=0, `ref_out`=0, `p_act`=0, `m_act`=0.
  - Pending set = 0, `pend_flag`=0.
  - State IDLE.
  - `period_end`, `peak`, `load_ack` = 0.
- Reset in mid-period discards pending and active values.

## Timing
- All outputs are registered. The comparator sees `count` and `ref_out` from the same edge.
- `load` at cycle n → pending valid at n+1. Active at the first boundary edge ≥ n+1. `load_ack` high one cycle after that edge.
- Sawtooth period is P+1 cycles. Triangle period is 2P cycles for P ≥ 1.
- `period_end` and `load_ack` coincide when an update applies.
- A new `mode` takes effect from `count`=0 of the next period. There is no mid-ramp direction change.

## Structure
- Shared package `pwm_pkg`:
  - State enum {IDLE, UP, DOWN}.
  - `PWM_WIDTH` = 16.
  - Mode constants `MODE_SAW` = 0, `MODE_TRI` = 1.
- One natural sub-module, `pwm_shadow_reg`: the pending/active double buffer with `pend_flag` and `load_ack`, driven by a `boundary` strobe from the counter FSM.
- Counter and FSM stay in the top module.

## Test plan
- **Reset:** reset, `en`=1, no load → `count` stays 0, `period_end` high every cycle, `ref_out`=0.
- **Sawtooth:** `load` P=9, duty=4, mode 0, then `en`=1 → `count` 0..9 repeating. `period_end` every 10 cycles. Comparator output high for 5 of 10 cycles.
- **Triangle:** `load` P=4, mode 1 → `count` 0,1,2,3,4,3,2,1,0… `peak` at each 4. `period_end` every 8 cycles.
- **Shadowing:** mid-period `load` P=3, duty=1 while P=9 is active → `count` completes to 9 first. `load_ack` and `period_end` pulse together. Next period is 0..3 with `ref_out`=1.
- **Double load and boundary collision:** two loads (duty 2, then 7) in one period → one `load_ack`, `ref_out`=7. A `load` on the boundary edge applies one period later.
- **Freeze and reset:** `en`=0 at `count`=5 for 3 cycles → `count` holds 5, no pulses. `rst` at `count`=6 → all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM carrier path.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 16;

    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StUp,
        StDown
    } pwm_state_e;

endpackage

// File: rtl/pwm_carrier_gen_shadow.sv
// Pending/active double buffer for period, duty and mode.
// Pending values move to the active set only on a carrier boundary strobe.
module pwm_shadow_reg
    import pwm_pkg::*;
#(
    parameter int unsigned Width = PWM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             boundary_i,
    input  logic [Width-1:0] period_i,
    input  logic [Width-1:0] duty_i,
    input  logic             mode_i,
    output logic [Width-1:0] period_act_o,
    output logic [Width-1:0] duty_act_o,
    output logic             mode_act_o,
    output logic             load_ack_o
);

    logic [Width-1:0] p_pend_q, p_pend_d;
    logic [Width-1:0] d_pend_q, d_pend_d;
    logic             m_pend_q, m_pend_d;
    logic             pend_flag_q, pend_flag_d;
    logic [Width-1:0] p_act_q, p_act_d;
    logic [Width-1:0] d_act_q, d_act_d;
    logic             m_act_q, m_act_d;
    logic             load_ack_q, load_ack_d;
    logic             apply;

    // The boundary consumes the old pending contents; a coincident load refills them.
    assign apply = boundary_i & pend_flag_q;

    always_comb begin
        p_pend_d    = p_pend_q;
        d_pend_d    = d_pend_q;
        m_pend_d    = m_pend_q;
        pend_flag_d = pend_flag_q;
        p_act_d     = p_act_q;
        d_act_d     = d_act_q;
        m_act_d     = m_act_q;
        load_ack_d  = apply;

        if (apply) begin
            p_act_d     = p_pend_q;
            d_act_d     = d_pend_q;
            m_act_d     = m_pend_q;
            pend_flag_d = 1'b0;
        end

        if (load_i) begin
            p_pend_d    = period_i;
            d_pend_d    = duty_i;
            m_pend_d    = mode_i;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_pend_q    <= '0;
            d_pend_q    <= '0;
            m_pend_q    <= MODE_SAW;
            pend_flag_q <= 1'b0;
            p_act_q     <= '0;
            d_act_q     <= '0;
            m_act_q     <= MODE_SAW;
            load_ack_q  <= 1'b0;
        end else begin
            p_pend_q    <= p_pend_d;
            d_pend_q    <= d_pend_d;
            m_pend_q    <= m_pend_d;
            pend_flag_q <= pend_flag_d;
            p_act_q     <= p_act_d;
            d_act_q     <= d_act_d;
            m_act_q     <= m_act_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign period_act_o = p_act_q;
    assign duty_act_o   = d_act_q;
    assign mode_act_o   = m_act_q;
    assign load_ack_o   = load_ack_q;

endmodule

// File: rtl/pwm_carrier_gen.sv
// PWM carrier generator: sawtooth/triangle ramp with a boundary-synchronised
// double-buffered period, duty and mode.
module pwm_carrier_gen
    import pwm_pkg::*;
#(
    parameter int unsigned Width = PWM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [Width-1:0] period_i,
    input  logic [Width-1:0] duty_i,
    input  logic             load_i,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] ref_out_o,
    output logic             period_end_o,
    output logic             peak_o,
    output logic             load_ack_o
);

    pwm_state_e       state_q;
    logic [Width-1:0] count_q;
    logic [Width-1:0] count_inc;
    logic             period_end_q;
    logic             peak_q;
    logic             boundary;
    logic [Width-1:0] p_act;
    logic             m_act;

    assign count_inc = count_q + 1'b1;

    // A boundary is any enabled edge whose next count is the wrap to 0.
    // Triangle with P <= 1 has no down leg, so its peak edge is the boundary.
    always_comb begin
        boundary = 1'b0;
        if (en_i) begin
            unique case (state_q)
                StIdle:  boundary = 1'b1;
                StUp:    boundary = (count_q >= p_act) &&
                                    ((m_act == MODE_SAW) || (p_act <= Width'(1)));
                StDown:  boundary = (count_q <= Width'(1));
                default: boundary = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            count_q      <= '0;
            period_end_q <= 1'b0;
            peak_q       <= 1'b0;
        end else begin
            period_end_q <= boundary;
            peak_q       <= 1'b0;
            if (en_i) begin
                if (boundary) begin
                    state_q <= StUp;
                    count_q <= '0;
                end else begin
                    unique case (state_q)
                        StUp: begin
                            if (count_q < p_act) begin
                                count_q <= count_inc;
                                peak_q  <= (m_act == MODE_TRI) && (count_inc == p_act);
                            end else begin
                                state_q <= StDown;
                                count_q <= p_act - 1'b1;
                            end
                        end
                        StDown:  count_q <= count_q - 1'b1;
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    pwm_shadow_reg #(
        .Width(Width)
    ) u_shadow (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load_i),
        .boundary_i  (boundary),
        .period_i    (period_i),
        .duty_i      (duty_i),
        .mode_i      (mode_i),
        .period_act_o(p_act),
        .duty_act_o  (ref_out_o),
        .mode_act_o  (m_act),
        .load_ack_o  (load_ack_o)
    );

    assign count_o      = count_q;
    assign period_end_o = period_end_q;
    assign peak_o       = peak_q;

endmodule
